// File: rtl/mem_stage.sv
// Memory pipeline stage: EX/MEM register, data-bus access sequencing with
// timeout, load alignment/extension and the MEM/WB register.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no access outstanding; a held mem op requests the bus here
// S_WAIT | request issued and not yet acknowledged; upstream stalled
module mem_stage #(
   parameter int MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [6:0]  opcode_EX,
   input  logic [2:0]  funct3_EX,
   input  logic [4:0]  rd_EX,
   input  logic [31:0] res_EX,
   input  logic [31:0] x2_EX,
   output logic [4:0]  rd_MEM,
   output logic [31:0] res_MEM,
   output logic        stall_MEM,
   output logic        d_req,
   output logic        d_we,
   output logic [31:0] d_addr,
   output logic [3:0]  d_be,
   output logic [31:0] d_wdata,
   input  logic        d_ack,
   input  logic [31:0] d_rdata,
   output logic [4:0]  rd_WB,
   output logic [31:0] res_WB,
   output logic        misalign_err,
   output logic        bus_err
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam int         CW        = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
   // the last unacknowledged WAIT cycle is the one where the count reaches MAX_WAIT-1
   localparam logic [CW-1:0] TO_CNT = (MAX_WAIT > 0) ? CW'(MAX_WAIT - 1) : '0;

   typedef enum logic [0:0] {S_IDLE, S_WAIT} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [6:0]    op_q;
   logic [2:0]    f3_q;
   logic [4:0]    rd_q;
   logic [31:0]   res_q, x2_q;
   logic [4:0]    rd_wb_q, rd_wb_d;
   logic [31:0]   res_wb_q, res_wb_d;
   logic          mis_q, mis_d, berr_q, berr_d;

   logic          is_load, is_store, mem_op, f3_ok, misal, op_err, valid_mem, timeout;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [31:0]   ld_data;

   // EX/MEM register, frozen while the bus access is pending
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_q  <= '0;
         f3_q  <= '0;
         rd_q  <= '0;
         res_q <= '0;
         x2_q  <= '0;
      end else if (!stall_MEM) begin
         op_q  <= opcode_EX;
         f3_q  <= funct3_EX;
         rd_q  <= rd_EX;
         res_q <= res_EX;
         x2_q  <= x2_EX;
      end
   end

   // decode of the held op: legality of funct3 and address alignment
   always_comb begin
      is_load  = (op_q == OP_LOAD);
      is_store = (op_q == OP_STORE);
      mem_op   = is_load | is_store;
      f3_ok    = 1'b0;
      if (is_load)
         f3_ok = (f3_q == 3'b000) | (f3_q == 3'b001) | (f3_q == 3'b010) |
                 (f3_q == 3'b100) | (f3_q == 3'b101);
      else if (is_store)
         f3_ok = (f3_q == 3'b000) | (f3_q == 3'b001) | (f3_q == 3'b010);
      misal     = (((f3_q == 3'b001) | (f3_q == 3'b101)) & res_q[0]) |
                  ((f3_q == 3'b010) & (res_q[1:0] != 2'b00));
      op_err    = mem_op & (~f3_ok | misal);
      valid_mem = mem_op & ~op_err;
      timeout   = (MAX_WAIT > 0) && (state_q == S_WAIT) && !d_ack && (cnt_q == TO_CNT);
   end

   // FSM state and wait-counter registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // FSM next state; the counter only runs across unacknowledged WAIT cycles
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      case (state_q)
         S_IDLE: if (valid_mem && !d_ack) state_d = S_WAIT;
         S_WAIT: begin
            if (d_ack || timeout) state_d = S_IDLE;
            else                  cnt_d   = cnt_q + CW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs; a timeout releases the stall so the aborted op is dropped
   always_comb begin
      d_req     = 1'b0;
      stall_MEM = 1'b0;
      case (state_q)
         S_IDLE: begin
            d_req     = valid_mem;
            stall_MEM = valid_mem & ~d_ack;
         end
         S_WAIT: begin
            d_req     = 1'b1;
            stall_MEM = ~d_ack & ~timeout;
         end
         default: ;
      endcase
   end

   // bus address/lane encoding, all derived from the held op so stable during a request
   always_comb begin
      d_we    = is_store;
      d_addr  = {res_q[31:2], 2'b00};
      d_be    = 4'b0000;
      d_wdata = '0;
      if (is_store) begin
         case (f3_q)
            3'b000: begin
               d_be    = 4'b0001 << res_q[1:0];
               d_wdata = {4{x2_q[7:0]}};
            end
            3'b001: begin
               d_be    = res_q[1] ? 4'b1100 : 4'b0011;
               d_wdata = {2{x2_q[15:0]}};
            end
            default: begin
               d_be    = 4'b1111;
               d_wdata = x2_q;
            end
         endcase
      end
   end

   // load lane selection and sign/zero extension
   always_comb begin
      case (res_q[1:0])
         2'b00:   byte_sel = d_rdata[7:0];
         2'b01:   byte_sel = d_rdata[15:8];
         2'b10:   byte_sel = d_rdata[23:16];
         default: byte_sel = d_rdata[31:24];
      endcase
      half_sel = res_q[1] ? d_rdata[31:16] : d_rdata[15:0];
      case (f3_q)
         3'b000:  ld_data = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  ld_data = {24'b0, byte_sel};
         3'b001:  ld_data = {{16{half_sel[15]}}, half_sel};
         3'b101:  ld_data = {16'b0, half_sel};
         default: ld_data = d_rdata;
      endcase
   end

   // writeback selection; waiting cycles present a bubble (rd_WB=0)
   always_comb begin
      rd_wb_d  = '0;
      res_wb_d = res_wb_q;
      mis_d    = 1'b0;
      berr_d   = 1'b0;
      if (!mem_op) begin
         rd_wb_d  = (op_q == OP_BRANCH) ? 5'd0 : rd_q;
         res_wb_d = res_q;
      end else if (op_err) begin
         mis_d = 1'b1;
      end else if (d_ack) begin
         if (is_load) begin
            rd_wb_d  = rd_q;
            res_wb_d = ld_data;
         end
      end else if (timeout) begin
         berr_d = 1'b1;
      end
   end

   // MEM/WB register and error pulses
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_wb_q  <= '0;
         res_wb_q <= '0;
         mis_q    <= 1'b0;
         berr_q   <= 1'b0;
      end else begin
         rd_wb_q  <= rd_wb_d;
         res_wb_q <= res_wb_d;
         mis_q    <= mis_d;
         berr_q   <= berr_d;
      end
   end

   // loads, stores and branches never forward through rd_MEM
   assign rd_MEM       = (mem_op || op_q == OP_BRANCH) ? 5'd0 : rd_q;
   assign res_MEM      = res_q;
   assign rd_WB        = rd_wb_q;
   assign res_WB       = res_wb_q;
   assign misalign_err = mis_q;
   assign bus_err      = berr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table through a scoreboard, plus hand-written
// sequences for stall/no-bubble pipelining and reset during a bus wait.
module tb_mem_stage;

   localparam logic [6:0] OP_ALU = 7'b0010011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_ST  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [6:0]  opcode_EX;
   logic [2:0]  funct3_EX;
   logic [4:0]  rd_EX;
   logic [31:0] res_EX, x2_EX;
   logic [4:0]  rd_MEM;
   logic [31:0] res_MEM;
   logic        stall_MEM, d_req, d_we;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [3:0]  d_be;
   logic        d_ack;
   logic [4:0]  rd_WB;
   logic [31:0] res_WB;
   logic        misalign_err, bus_err;

   always #5 clk = ~clk;

   mem_stage #(.MAX_WAIT(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .opcode_EX(opcode_EX), .funct3_EX(funct3_EX), .rd_EX(rd_EX),
      .res_EX(res_EX), .x2_EX(x2_EX),
      .rd_MEM(rd_MEM), .res_MEM(res_MEM), .stall_MEM(stall_MEM),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .rd_WB(rd_WB), .res_WB(res_WB),
      .misalign_err(misalign_err), .bus_err(bus_err)
   );

   typedef struct {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [31:0] res, x2, rdata;
      int          nwait;      // ack on request cycle nwait+1; -1 never acks
      bit          ack_noise;  // hold d_ack high while no request is out
      int          e_nreq;
      bit          e_we;
      logic [31:0] e_addr;
      logic [3:0]  e_be;
      logic [31:0] e_wdata;
      logic [4:0]  e_rd_mem, e_rd_wb;
      bit          e_chk_res;
      logic [31:0] e_res_wb;
      bit          e_mis, e_berr;
   } vec_t;

   typedef struct {
      logic [4:0]  rd_wb;
      bit          chk_res;
      logic [31:0] res_wb;
      bit          mis, berr;
   } sb_t;

   int   checks = 0;
   int   failures = 0;
   sb_t  sb[$];
   vec_t vecs[16];

   function automatic vec_t mk(logic [6:0] op, logic [2:0] f3, logic [4:0] rd,
                               logic [31:0] res, logic [31:0] x2, logic [31:0] rdata,
                               int nwait, bit ack_noise, int e_nreq, bit e_we,
                               logic [31:0] e_addr, logic [3:0] e_be, logic [31:0] e_wdata,
                               logic [4:0] e_rd_mem, logic [4:0] e_rd_wb, bit e_chk_res,
                               logic [31:0] e_res_wb, bit e_mis, bit e_berr);
      vec_t v;
      v.op = op; v.f3 = f3; v.rd = rd; v.res = res; v.x2 = x2; v.rdata = rdata;
      v.nwait = nwait; v.ack_noise = ack_noise; v.e_nreq = e_nreq; v.e_we = e_we;
      v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata; v.e_rd_mem = e_rd_mem;
      v.e_rd_wb = e_rd_wb; v.e_chk_res = e_chk_res; v.e_res_wb = e_res_wb;
      v.e_mis = e_mis; v.e_berr = e_berr;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive_ex(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] res, input logic [31:0] x2);
      opcode_EX = op; funct3_EX = f3; rd_EX = rd; res_EX = res; x2_EX = x2;
   endtask

   task automatic drive_nop();
      drive_ex(OP_ALU, 3'b000, 5'd0, 32'h0, 32'h0);
   endtask

   // entered just after a falling edge; returns just after a falling edge
   task automatic run_vec(input int idx, input vec_t v);
      int  nreq;
      bit  fin;
      sb_t e, got;
      string tag;
      tag = $sformatf("v%0d", idx);
      drive_ex(v.op, v.f3, v.rd, v.res, v.x2);
      d_ack = 1'b0;
      e.rd_wb = v.e_rd_wb; e.chk_res = v.e_chk_res; e.res_wb = v.e_res_wb;
      e.mis = v.e_mis; e.berr = v.e_berr;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      drive_nop();
      #1;
      chk({tag, ".rd_MEM"},  32'(rd_MEM), 32'(v.e_rd_mem));
      chk({tag, ".res_MEM"}, res_MEM, v.res);
      chk({tag, ".mis_idle"}, 32'(misalign_err), 32'd0);
      chk({tag, ".berr_idle"}, 32'(bus_err), 32'd0);
      nreq = 0;
      fin  = 1'b0;
      for (int c = 0; c < 40 && !fin; c++) begin
         if (!d_req) begin
            fin = 1'b1;
            if (nreq == 0) begin
               chk({tag, ".stall_nomem"}, 32'(stall_MEM), 32'd0);
               d_ack   = v.ack_noise;
               d_rdata = 32'hBAD0_BAD0;
               @(posedge clk);
               @(negedge clk);
               d_ack = 1'b0;
               #1;
            end
         end else begin
            nreq++;
            chk({tag, ".d_we"},   32'(d_we), 32'(v.e_we));
            chk({tag, ".d_addr"}, d_addr, v.e_addr);
            chk({tag, ".d_be"},   32'(d_be), 32'(v.e_be));
            if (v.e_we) chk({tag, ".d_wdata"}, d_wdata, v.e_wdata);
            if (v.nwait == nreq - 1) begin
               d_ack   = 1'b1;
               d_rdata = v.rdata;
               #1;
               chk({tag, ".stall_ack"}, 32'(stall_MEM), 32'd0);
               @(posedge clk);
               @(negedge clk);
               d_ack   = 1'b0;
               d_rdata = 32'h0;
               #1;
               fin = 1'b1;
            end else begin
               if (v.nwait >= 0) chk({tag, ".stall_wait"}, 32'(stall_MEM), 32'd1);
               @(posedge clk);
               @(negedge clk);
               #1;
            end
         end
      end
      if (!fin) begin
         failures++;
         $display("FAIL %s.bound: d_req still high after 40 cycles", tag);
      end
      chk({tag, ".nreq"}, 32'(nreq), 32'(v.e_nreq));
      if (sb.size() == 0) begin
         failures++;
         $display("FAIL %s.sb: scoreboard empty", tag);
      end else begin
         got = sb.pop_front();
         chk({tag, ".rd_WB"}, 32'(rd_WB), 32'(got.rd_wb));
         if (got.chk_res) chk({tag, ".res_WB"}, res_WB, got.res_wb);
         chk({tag, ".misalign_err"}, 32'(misalign_err), 32'(got.mis));
         chk({tag, ".bus_err"}, 32'(bus_err), 32'(got.berr));
         chk({tag, ".stall_after"}, 32'(stall_MEM), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //            op     f3      rd  res           x2            rdata        nw ns nrq we addr          be       wdata         rdM rdW chk res_wb       mis berr
      vecs[0]  = mk(OP_ALU,3'b000, 5, 32'h0000_1234,32'h0,        32'h0,        0, 1, 0, 0, 32'h0,       4'b0000, 32'h0,         5,  5, 1, 32'h0000_1234,0, 0);
      vecs[1]  = mk(OP_LD, 3'b000, 7, 32'h0000_0103,32'h0,        32'h80FF_FF00,2, 0, 3, 0, 32'h100,     4'b0000, 32'h0,         0,  7, 1, 32'hFFFF_FF80,0, 0);
      vecs[2]  = mk(OP_LD, 3'b100, 8, 32'h0000_0103,32'h0,        32'h80FF_FF00,2, 0, 3, 0, 32'h100,     4'b0000, 32'h0,         0,  8, 1, 32'h0000_0080,0, 0);
      vecs[3]  = mk(OP_ST, 3'b001, 9, 32'h0000_0202,32'hDEAD_BEEF,32'h0,        0, 0, 1, 1, 32'h200,     4'b1100, 32'hBEEF_BEEF, 0,  0, 0, 32'h0,        0, 0);
      vecs[4]  = mk(OP_LD, 3'b010,10, 32'h0000_0301,32'h0,        32'h0,        0, 1, 0, 0, 32'h0,       4'b0000, 32'h0,         0,  0, 0, 32'h0,        1, 0);
      vecs[5]  = mk(OP_LD, 3'b010,11, 32'h0000_0400,32'h0,        32'h0,       -1, 0, 5, 0, 32'h400,     4'b0000, 32'h0,         0,  0, 0, 32'h0,        0, 1);
      vecs[6]  = mk(OP_LD, 3'b010,12, 32'h0000_0404,32'h0,        32'h1234_5678,4, 0, 5, 0, 32'h404,     4'b0000, 32'h0,         0, 12, 1, 32'h1234_5678,0, 0);
      vecs[7]  = mk(OP_ST, 3'b000, 3, 32'h0000_1003,32'h0000_00A5,32'h0,        1, 0, 2, 1, 32'h1000,    4'b1000, 32'hA5A5_A5A5, 0,  0, 0, 32'h0,        0, 0);
      vecs[8]  = mk(OP_ST, 3'b010, 4, 32'h0000_2000,32'hCAFE_F00D,32'h0,        0, 0, 1, 1, 32'h2000,    4'b1111, 32'hCAFE_F00D, 0,  0, 0, 32'h0,        0, 0);
      vecs[9]  = mk(OP_LD, 3'b001,13, 32'h0000_0012,32'h0,        32'h8001_7FFE,1, 0, 2, 0, 32'h10,      4'b0000, 32'h0,         0, 13, 1, 32'hFFFF_8001,0, 0);
      vecs[10] = mk(OP_LD, 3'b101,14, 32'h0000_0010,32'h0,        32'h8001_F00F,0, 0, 1, 0, 32'h10,      4'b0000, 32'h0,         0, 14, 1, 32'h0000_F00F,0, 0);
      vecs[11] = mk(OP_BR, 3'b000,15, 32'h0000_0055,32'h0,        32'h0,        0, 0, 0, 0, 32'h0,       4'b0000, 32'h0,         0,  0, 1, 32'h0000_0055,0, 0);
      vecs[12] = mk(OP_LD, 3'b011,16, 32'h0000_0000,32'h0,        32'h0,        0, 0, 0, 0, 32'h0,       4'b0000, 32'h0,         0,  0, 0, 32'h0,        1, 0);
      vecs[13] = mk(OP_ST, 3'b100,17, 32'h0000_0000,32'h0,        32'h0,        0, 1, 0, 0, 32'h0,       4'b0000, 32'h0,         0,  0, 0, 32'h0,        1, 0);
      vecs[14] = mk(OP_LD, 3'b001,18, 32'h0000_0007,32'h0,        32'h0,        0, 0, 0, 0, 32'h0,       4'b0000, 32'h0,         0,  0, 0, 32'h0,        1, 0);
      vecs[15] = mk(OP_LD, 3'b000,19, 32'h0000_0002,32'h0,        32'h007F_0000,0, 0, 1, 0, 32'h0,       4'b0000, 32'h0,         0, 19, 1, 32'h0000_007F,0, 0);

      reset_n = 1'b0;
      d_ack   = 1'b0;
      d_rdata = 32'h0;
      drive_nop();
      repeat (2) @(negedge clk);
      #1;
      chk("rst.rd_MEM", 32'(rd_MEM), 32'd0);
      chk("rst.res_MEM", res_MEM, 32'h0);
      chk("rst.stall", 32'(stall_MEM), 32'd0);
      chk("rst.d_req", 32'(d_req), 32'd0);
      chk("rst.rd_WB", 32'(rd_WB), 32'd0);
      chk("rst.res_WB", res_WB, 32'h0);
      chk("rst.mis", 32'(misalign_err), 32'd0);
      chk("rst.berr", 32'(bus_err), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;

      for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

      // load held by a 1-cycle wait while the next ALU op sits in EX; it must
      // enter EX/MEM on the completion edge and reach WB one cycle later
      drive_ex(OP_LD, 3'b010, 5'd20, 32'h0000_0040, 32'h0);
      @(posedge clk);
      @(negedge clk);
      drive_ex(OP_ALU, 3'b000, 5'd21, 32'h0000_0077, 32'h0);
      #1;
      chk("pipe.stall", 32'(stall_MEM), 32'd1);
      chk("pipe.rd_MEM_load", 32'(rd_MEM), 32'd0);
      @(posedge clk);
      @(negedge clk);
      d_ack   = 1'b1;
      d_rdata = 32'hAABB_CCDD;
      #1;
      chk("pipe.held_res", res_MEM, 32'h0000_0040);
      chk("pipe.stall_ack", 32'(stall_MEM), 32'd0);
      @(posedge clk);
      @(negedge clk);
      d_ack = 1'b0;
      drive_nop();
      #1;
      chk("pipe.rd_WB_ld", 32'(rd_WB), 32'd20);
      chk("pipe.res_WB_ld", res_WB, 32'hAABB_CCDD);
      chk("pipe.rd_MEM_alu", 32'(rd_MEM), 32'd21);
      chk("pipe.res_MEM_alu", res_MEM, 32'h0000_0077);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("pipe.rd_WB_alu", 32'(rd_WB), 32'd21);
      chk("pipe.res_WB_alu", res_WB, 32'h0000_0077);

      // reset while waiting for an ack drops the request without a clock
      drive_ex(OP_LD, 3'b010, 5'd3, 32'h0000_0500, 32'h0);
      @(posedge clk);
      @(negedge clk);
      drive_nop();
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("rstw.d_req_before", 32'(d_req), 32'd1);
      chk("rstw.stall_before", 32'(stall_MEM), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("rstw.d_req", 32'(d_req), 32'd0);
      chk("rstw.stall", 32'(stall_MEM), 32'd0);
      chk("rstw.rd_MEM", 32'(rd_MEM), 32'd0);
      chk("rstw.res_MEM", res_MEM, 32'h0);
      chk("rstw.rd_WB", 32'(rd_WB), 32'd0);
      chk("rstw.res_WB", res_WB, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      #1;
      chk("rstw.d_req_after", 32'(d_req), 32'd0);
      chk("rstw.stall_after", 32'(stall_MEM), 32'd0);
      chk("rstw.errs_after", {30'd0, misalign_err, bus_err}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Registers the EX result (res_EX, x2_EX, rd_EX) into an EX/MEM register and performs LOAD/STORE accesses on a valid/ack data bus.
- Aligns and sign-extends load data, then registers the final result into a MEM/WB register.
- Feeds rd_MEM/res_MEM back to EX for forwarding and stalls upstream while a bus access is pending.

Parameters:
- MAX_WAIT, 255: cycles a request may stay unacknowledged before abort with bus_err. 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- opcode_EX  in  7  opcode of instruction leaving EX
- funct3_EX  in  3  width/sign field (000 B, 001 H, 010 W, 100 BU, 101 HU)
- rd_EX  in  5  destination register
- res_EX  in  32  ALU result; the address for LOAD/STORE
- x2_EX  in  32  forwarded rs2 value; store data
- rd_MEM  out  5  rd held in EX/MEM register, for forwarding; 0 when the held op is LOAD, STORE or BRANCH
- res_MEM  out  32  res held in EX/MEM register
- stall_MEM  out  1  upstream must hold its state this cycle
- d_req  out  1  bus request
- d_we  out  1  1 = store
- d_addr  out  32  word-aligned address ({res[31:2],2'b00})
- d_be  out  4  byte enables (stores only; 0 on loads)
- d_wdata  out  32  store data, lane-replicated
- d_ack  in  1  bus completes the access this cycle
- d_rdata  in  32  load word, valid with d_ack
- rd_WB  out  5  registered destination for writeback; 0 = no write
- res_WB  out  32  registered writeback value
- misalign_err  out  1  one-cycle pulse: misaligned access or illegal funct3
- bus_err  out  1  one-cycle pulse: timeout abort

Behaviour:
- Reset: all registers 0, FSM in IDLE, all outputs 0 (rd_MEM=0, res_MEM=0, stall_MEM=0, d_req=0, rd_WB=0, res_WB=0, both error flags 0).
  - Reset asserted mid-access drops d_req immediately; the instruction is lost.
- EX/MEM register: loads opcode/funct3/rd/res/x2 on every edge where stall_MEM=0.
  - Holds its value while stall_MEM=1.
  - A held opcode that is neither LOAD (0000011) nor STORE (0100011) is "non-mem".
- Non-mem op:
  - No bus activity; stall_MEM=0.
  - Next edge: rd_WB <= rd (0 if BRANCH or STORE), res_WB <= res.
  - Latency 1 cycle MEM to WB.
- Alignment check, combinational on held op:
  - H/HU with res[0]=1 is misaligned; W with res[1:0]!=0 is misaligned.
  - Funct3 outside the listed set (and STORE with 100/101) is illegal.
  - On either: no d_req, stall_MEM=0, next edge rd_WB <= 0 and misalign_err pulses high for 1 cycle.
- FSM states: IDLE, WAIT.
  - IDLE with a valid mem op: d_req=1 combinationally. If d_ack=1 in the same cycle, the op completes (0-wait). Otherwise go to WAIT, with stall_MEM=1 that cycle.
  - WAIT: d_req=1, stall_MEM=!d_ack. On d_ack, complete and return to IDLE.
  - d_addr, d_we, d_be and d_wdata are stable while d_req=1.
- Completion edge:
  - Load: rd_WB <= rd, res_WB <= extracted data.
  - Store: rd_WB <= 0.
  - Completion and capture of the next EX instruction happen on the same edge (no bubble).
- Load extraction by res[1:0]:
  - LB/LBU: byte lane res[1:0], sign- or zero-extended.
  - LH/LHU: lane res[1], sign- or zero-extended.
  - LW: full word.
- Store encoding:
  - SB: d_be = 4'b0001 << res[1:0], d_wdata = {4{x2[7:0]}}.
  - SH: d_be = res[1] ? 1100 : 0011, d_wdata = {2{x2[15:0]}}.
  - SW: d_be = 1111, d_wdata = x2.
- Wait counter:
  - Clears in IDLE; increments each cycle in WAIT without d_ack.
  - When counter == MAX_WAIT (MAX_WAIT>0): abort the access — d_req=0 next cycle, return to IDLE, rd_WB <= 0, bus_err pulses 1 cycle, stall released.
  - d_ack in the same cycle as the timeout wins: normal completion.
- d_ack received while d_req=0 is ignored.
- Load-use hazard detection is upstream's responsibility; this stage never forwards load data through rd_MEM.

Test Plan:
- ALU op: rd_EX=5, res_EX=0x1234 -> next cycle rd_MEM=5, res_MEM=0x1234; following cycle rd_WB=5, res_WB=0x1234; d_req never 1.
- LB, addr 0x103, d_rdata=0x80FF_FF00, ack after 2 wait cycles -> d_addr=0x100, d_be=0, stall_MEM high for 2 cycles, res_WB=0xFFFF_FF80. LBU on the same data -> res_WB=0x80.
- SH, addr 0x202, x2=0xDEAD_BEEF, 0-wait ack -> d_we=1, d_be=1100, d_wdata=0xBEEF_BEEF, stall_MEM=0, rd_WB=0.
- LW, addr 0x301 -> no d_req, misalign_err pulse 1 cycle, rd_WB=0.
- MAX_WAIT=4, LW with no ack -> d_req high 5 cycles, then bus_err pulse, rd_WB=0, stall released.
- reset_n low in WAIT state -> d_req=0 and stall_MEM=0 asynchronously; after release, FSM IDLE and all outputs 0.
